// File: rtl/rr_arb_vn_p_pkg.sv
// Shared helpers for the VN/VC round-robin arbiter: index-width function.
// Optional feature macro used by this slice: RR_VN_P_AVAIL_MASK_EN.
package rr_arb_vn_p_pkg;

  // Ceiling log2, never below 1 so a 2-slot vector still gets a 1-bit index.
  function automatic int log2c(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_vn_p_rot.sv
// Combinational right-rotate of the flattened VN x VC request vector.
// No state, no latency; shift = 0 passes the vector through unchanged.
module rot_right_vn_p
  import rr_arb_vn_p_pkg::*;
#(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  localparam int NUM_VN_X_VC = NUM_VC * NUM_VN,
  localparam int bits_VN_X_VC = log2c(NUM_VN_X_VC)
) (
  input  logic [NUM_VN_X_VC-1:0]  vector_in,
  input  logic [bits_VN_X_VC-1:0] shift,
  output logic [NUM_VN_X_VC-1:0]  vector_out
);

  // A left shift by the full width yields zero, so shift = 0 needs no special case.
  assign vector_out = (vector_in >> shift) | (vector_in << (NUM_VN_X_VC - int'(shift)));

endmodule

// File: rtl/rr_arb_vn_p.sv
// Registered round-robin arbiter over the VN x VC request vector; grant held until grant_ack.
// Optional vc_avail masking is compiled in with RR_VN_P_AVAIL_MASK_EN.
module rr_arb_vn_p
  import rr_arb_vn_p_pkg::*;
#(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  localparam int NUM_VN_X_VC = NUM_VC * NUM_VN,
  localparam int bits_VN_X_VC = log2c(NUM_VN_X_VC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VN_X_VC-1:0]  req,
`ifdef RR_VN_P_AVAIL_MASK_EN
  input  logic [NUM_VN_X_VC-1:0]  vc_avail,
`endif
  output logic [NUM_VN_X_VC-1:0]  grant,
  output logic                    grant_vld,
  output logic [bits_VN_X_VC-1:0] grant_idx,
  input  logic                    grant_ack
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                  state, state_d;
  logic [bits_VN_X_VC-1:0] ptr, ptr_d;
  logic [NUM_VN_X_VC-1:0]  grant_d;
  logic [bits_VN_X_VC-1:0] idx_d;
  logic [NUM_VN_X_VC-1:0]  eff, rot;
  logic [bits_VN_X_VC-1:0] pos, win;
  logic [bits_VN_X_VC:0]   sum;

`ifdef RR_VN_P_AVAIL_MASK_EN
  assign eff = req & vc_avail;
`else
  assign eff = req;
`endif

  rot_right_vn_p #(.NUM_VC(NUM_VC), .NUM_VN(NUM_VN)) u_rot (
    .vector_in  (eff),
    .shift      (ptr),
    .vector_out (rot)
  );

  // Lowest set bit of the rotated vector is the highest-priority requester.
  always_comb begin
    pos = '0;
    for (int i = NUM_VN_X_VC - 1; i >= 0; i--) begin
      if (rot[i]) pos = bits_VN_X_VC'(i);
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= (bits_VN_X_VC + 1)'(NUM_VN_X_VC))
      win = sum[bits_VN_X_VC-1:0] - bits_VN_X_VC'(NUM_VN_X_VC);
    else
      win = sum[bits_VN_X_VC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      grant_idx <= idx_d;
      ptr       <= ptr_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (eff != '0) state_d = GRANTED;
      GRANTED: if (grant_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant;
    idx_d   = grant_idx;
    ptr_d   = ptr;
    case (state)
      IDLE: begin
        if (eff != '0) begin
          grant_d = NUM_VN_X_VC'(1) << win;
          idx_d   = win;
        end else begin
          grant_d = '0;
          idx_d   = '0;
        end
      end
      GRANTED: begin
        if (grant_ack) begin
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = (grant_idx == bits_VN_X_VC'(NUM_VN_X_VC - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign grant_vld = |grant;

endmodule

// File: tb/tb_rr_arb_vn_p.sv
// Directed bench for rr_arb_vn_p (NUM_VN=3, NUM_VC=1): vector table plus hand sequences.
module tb_rr_arb_vn_p;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] vc_avail;
  logic [2:0] grant;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic       grant_ack;

  int n_checks;
  int n_fail;

  rr_arb_vn_p #(.NUM_VC(1), .NUM_VN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef RR_VN_P_AVAIL_MASK_EN
    .vc_avail  (vc_avail),
`endif
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .grant_ack (grant_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       ack;
    logic [2:0] g;
    logic [1:0] idx;
    logic [1:0] ptr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, sample #1 after the following rising edge.
  task automatic step(input logic r, input logic [2:0] q, input logic a);
    @(negedge clk);
    rst       = r;
    req       = q;
    grant_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] g, input logic [1:0] idx,
                            input logic [1:0] p);
    check({name, ".grant"}, 32'(grant), 32'(g));
    check({name, ".idx"}, 32'(grant_idx), 32'(idx));
    check({name, ".vld"}, 32'(grant_vld), 32'(g != 3'b000));
    check({name, ".ptr"}, 32'(dut.ptr), 32'(p));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req       = 3'b000;
    grant_ack = 1'b0;
    vc_avail  = 3'b111;

    //          rst   req     ack   grant   idx  ptr
    vecs[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 2'd0};
    vecs[1]  = '{1'b0, 3'b111, 1'b0, 3'b001, 2'd0, 2'd0};
    vecs[2]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 2'd1};
    // Ack held high: ignored in IDLE, so grants land every second cycle.
    vecs[3]  = '{1'b0, 3'b111, 1'b1, 3'b010, 2'd1, 2'd1};
    vecs[4]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 2'd2};
    vecs[5]  = '{1'b0, 3'b111, 1'b1, 3'b100, 2'd2, 2'd2};
    vecs[6]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 2'd0};
    vecs[7]  = '{1'b0, 3'b111, 1'b1, 3'b001, 2'd0, 2'd0};
    vecs[8]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'd0, 2'd1};
    vecs[9]  = '{1'b0, 3'b010, 1'b0, 3'b010, 2'd1, 2'd1};
    vecs[10] = '{1'b0, 3'b010, 1'b1, 3'b000, 2'd0, 2'd2};
    // ptr=2, req=011: slot 2 idle, search wraps to slot 0; ack moves ptr to 1.
    vecs[11] = '{1'b0, 3'b011, 1'b0, 3'b001, 2'd0, 2'd2};
    vecs[12] = '{1'b0, 3'b011, 1'b1, 3'b000, 2'd0, 2'd1};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].ack);
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].idx, vecs[i].ptr);
    end

    // Hold: grant survives request withdrawal until acked.
    step(1'b0, 3'b111, 1'b0);
    expect_out("hold_start", 3'b010, 2'd1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b000, 1'b0);
      expect_out($sformatf("hold%0d", i), 3'b010, 2'd1, 2'd1);
    end
    step(1'b0, 3'b000, 1'b1);
    expect_out("hold_ack", 3'b000, 2'd0, 2'd2);

    // Idle with no requests: stray ack does nothing.
    step(1'b0, 3'b000, 1'b1);
    expect_out("idle0", 3'b000, 2'd0, 2'd2);
    step(1'b0, 3'b000, 1'b0);
    expect_out("idle1", 3'b000, 2'd0, 2'd2);

    // Reset mid-grant together with ack.
    step(1'b0, 3'b111, 1'b0);
    expect_out("rstmid_grant", 3'b100, 2'd2, 2'd2);
    step(1'b1, 3'b111, 1'b1);
    expect_out("rstmid_clear", 3'b000, 2'd0, 2'd0);

    // Same, where an ack would have moved ptr to 2: reset must win.
    step(1'b0, 3'b111, 1'b0);
    expect_out("rst2_g0", 3'b001, 2'd0, 2'd0);
    step(1'b0, 3'b000, 1'b1);
    expect_out("rst2_ack", 3'b000, 2'd0, 2'd1);
    step(1'b0, 3'b111, 1'b0);
    expect_out("rst2_g1", 3'b010, 2'd1, 2'd1);
    step(1'b1, 3'b111, 1'b1);
    expect_out("rst2_clear", 3'b000, 2'd0, 2'd0);
    step(1'b0, 3'b111, 1'b0);
    expect_out("rst2_after", 3'b001, 2'd0, 2'd0);

`ifdef RR_VN_P_AVAIL_MASK_EN
    step(1'b1, 3'b000, 1'b0);
    expect_out("mask_rst", 3'b000, 2'd0, 2'd0);
    vc_avail = 3'b100;
    step(1'b0, 3'b111, 1'b0);
    expect_out("mask_g2", 3'b100, 2'd2, 2'd0);
    step(1'b0, 3'b111, 1'b1);
    expect_out("mask_ack", 3'b000, 2'd0, 2'd0);
    vc_avail = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111, 1'b0);
      expect_out($sformatf("mask_none%0d", i), 3'b000, 2'd0, 2'd0);
    end
    vc_avail = 3'b010;
    step(1'b0, 3'b111, 1'b0);
    expect_out("mask_g1", 3'b010, 2'd1, 2'd0);
    vc_avail = 3'b000;
    step(1'b0, 3'b111, 1'b0);
    expect_out("mask_keep", 3'b010, 2'd1, 2'd0);
    step(1'b0, 3'b111, 1'b1);
    expect_out("mask_ack2", 3'b000, 2'd0, 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
